// File: rtl/seg_mmio_pkg.sv
// Shared constants and the CTRL register layout for the MMIO seven-segment responder.
// Register offsets are word indices taken from data_adr[3:2].
package seg_mmio_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BLINK_BIT  = 1;
  localparam int CTRL_BLANK_LSB  = 8;
  localparam int CTRL_BLANK_W    = 8;

  localparam int STATUS_IDX_W     = 3;
  localparam int STATUS_PHASE_BIT = 8;

  localparam int BLINK_FRAMES = 64;

  typedef struct packed {
    logic [CTRL_BLANK_W-1:0] blank;
    logic                    blink;
    logic                    en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                             = c.en;
    w[CTRL_BLINK_BIT]                          = c.blink;
    w[CTRL_BLANK_LSB +: CTRL_BLANK_W]          = c.blank;
    return w;
  endfunction

endpackage

// File: rtl/mmio_seg_responder_if.sv
// CPU data-bus view of the responder: store/load strobes, address, data and load response.
// Responses are fire-and-forget pulses; the bus has no backpressure.
interface mmio_seg_responder_if;
  logic        mem_write;
  logic        rd_en;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output mem_write, rd_en, data_adr, write_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  mem_write, rd_en, data_adr, write_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern, 0-F.
// Purely combinational, zero latency, no backpressure.
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_seg_responder.sv
// MMIO register window driving a multiplexed 7-seg display; blink built only with SEG_BLINK_EN.
// Loads answer 1 cycle after rd_en; no backpressure, every hit store/load is accepted.
module mmio_seg_responder
  import seg_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_seg_responder_if.slave   bus,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic                    hit;
  logic [1:0]              off;
  logic [DATA_W-1:0]       data_q;
  ctrl_t                   ctrl_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [STATUS_IDX_W-1:0] idx_q;
  logic                    scan_tc;
  logic                    last_idx;
  logic                    phase;
  logic                    blink_off;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;
  logic                    show;
  logic [31:0]             rd_mux;
  logic [31:0]             rd_data_q;
  logic                    rd_valid_q;
  logic                    unused_bits;

  assign off = bus.data_adr[3:2];
  assign hit = (bus.data_adr[31:4] == BASE_ADDR[31:4]) && (bus.data_adr[1:0] == 2'b00);

  // Only the low nibbles and a few CTRL bits are stored; the rest of a store is dropped.
  assign unused_bits = &{1'b0, bus.write_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (bus.mem_write && hit) begin
      case (off)
        OFF_DATA: data_q <= bus.write_data[DATA_W-1:0];
        OFF_CTRL: begin
          ctrl_q.en    <= bus.write_data[CTRL_EN_BIT];
          ctrl_q.blink <= bus.write_data[CTRL_BLINK_BIT];
          ctrl_q.blank <= bus.write_data[CTRL_BLANK_LSB +: CTRL_BLANK_W];
        end
        default: ;
      endcase
    end
  end

  assign scan_tc  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign last_idx = (idx_q == STATUS_IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (scan_tc) begin
      cnt_q <= '0;
      idx_q <= last_idx ? '0 : idx_q + STATUS_IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FRAME_W = $clog2(BLINK_FRAMES);
  logic [FRAME_W-1:0] frame_q;
  logic               phase_q;

  // A frame ends when the scan wraps back to digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (scan_tc && last_idx) begin
      frame_q <= frame_q + FRAME_W'(1);
      if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) phase_q <= ~phase_q;
    end
  end

  assign phase     = phase_q;
  assign blink_off = ctrl_q.blink && phase_q;
`else
  assign phase     = 1'b0;
  assign blink_off = 1'b0;
`endif

  assign nibble = data_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  assign show = ctrl_q.en && !ctrl_q.blank[idx_q] && !blink_off;

  // Both display outputs are registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      segments  <= 7'h7F;
      digit_sel <= '1;
    end else begin
      segments  <= ctrl_q.en ? seg_dec : 7'h7F;
      digit_sel <= show ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_DATA:   rd_mux = 32'(data_q);
      OFF_CTRL:   rd_mux = ctrl_to_word(ctrl_q);
      OFF_STATUS: begin
        rd_mux[STATUS_IDX_W-1:0]   = idx_q;
        rd_mux[STATUS_PHASE_BIT]   = phase;
      end
      default:    rd_mux = '0;
    endcase
  end

  // Sampling the mux before the store lands gives read-before-write on a shared cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en && hit;
      if (bus.rd_en && hit) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mmio_seg_responder.sv
// Bench for mmio_seg_responder: register vectors, scan order, blanking, async reset, optional blink.
`timescale 1ns/1ps
module tb_mmio_seg_responder;

  localparam int ND = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmio_seg_responder_if bus ();
  logic [6:0]    segments;
  logic [ND-1:0] digit_sel;

  mmio_seg_responder #(
    .BASE_ADDR  (32'h0000_0400),
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .segments  (segments),
    .digit_sel (digit_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        exp_vld;
    logic [31:0] exp_dat;
  } vec_t;
  vec_t vt[20];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read response monitor: each expected load must appear exactly on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        check("rd_valid", 32'(bus.rd_valid), 32'd1);
        if (bus.rd_valid) check("rd_data", bus.rd_data, e.dat);
      end else if (bus.rd_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_valid_spurious: got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic step(input logic we, input logic re, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic expv, input logic [31:0] expd);
    bus.mem_write  = we;
    bus.rd_en      = re;
    bus.data_adr   = adr;
    bus.write_data = wdat;
    if (expv) sbq.push_back('{dat: expd, due: cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.mem_write  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.data_adr   = 32'h0;
    bus.write_data = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [ND-1:0] v, input logic eq, input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if ((digit_sel == v) == eq) break;
      @(negedge clk);
    end
    n_cmp++;
    if (i == bound) begin
      n_bad++;
      $display("FAIL %s: digit_sel stuck at %b, wanted %s %b", name, digit_sel, eq ? "==" : "!=", v);
    end
  endtask

  // Aligns to the first cycle of the digit-0 slot, then checks four full slots.
  task automatic scan_check(input logic [4*ND-1:0] sels, input logic [7*ND-1:0] segs, input string name);
    wait_sel(4'b0111, 1'b1, 40, {name, "_align_a"});
    wait_sel(4'b0111, 1'b0, 40, {name, "_align_b"});
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < SD; c++) begin
        check({name, "_sel"}, 32'(digit_sel), 32'(sels[s*4 +: 4]));
        if (sels[s*4 +: 4] != 4'b1111) check({name, "_seg"}, 32'(segments), 32'(segs[s*7 +: 7]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h400, 32'h0,         1'b1, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 32'h404, 32'h0,         1'b1, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h400, 32'h1234,      1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 32'h400, 32'h0,         1'b1, 32'h1234};
    vt[4]  = '{1'b1, 1'b1, 32'h400, 32'hBEEF,      1'b1, 32'h1234};
    vt[5]  = '{1'b0, 1'b1, 32'h400, 32'h0,         1'b1, 32'hBEEF};
    vt[6]  = '{1'b1, 1'b0, 32'h402, 32'hFFFF,      1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h500, 32'h5555,      1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 32'h402, 32'h0,         1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 32'h500, 32'h0,         1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b1, 32'h400, 32'h0,         1'b1, 32'hBEEF};
    vt[11] = '{1'b1, 1'b1, 32'h40C, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[12] = '{1'b0, 1'b1, 32'h40C, 32'h0,         1'b1, 32'h0};
    vt[13] = '{1'b1, 1'b0, 32'h404, 32'hFFFF_0702, 1'b0, 32'h0};
    vt[14] = '{1'b0, 1'b1, 32'h404, 32'h0,         1'b1, 32'h0000_0702};
    vt[15] = '{1'b1, 1'b0, 32'h400, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[16] = '{1'b0, 1'b1, 32'h400, 32'h0,         1'b1, 32'h0000_FFFF};
    vt[17] = '{1'b1, 1'b0, 32'h408, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[18] = '{1'b0, 1'b1, 32'h404, 32'h0,         1'b1, 32'h0000_0702};
    vt[19] = '{1'b0, 1'b1, 32'h414, 32'h0,         1'b0, 32'h0};

    bus.mem_write  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.data_adr   = 32'h0;
    bus.write_data = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_rd_valid",  32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",   bus.rd_data,       32'h0);
    check("rst_segments",  32'(segments),     32'h7F);
    check("rst_digit_sel", 32'(digit_sel),    32'hF);
    rst = 1'b1;

    for (int i = 0; i < 20; i++)
      step(vt[i].we, vt[i].re, vt[i].adr, vt[i].wdat, vt[i].exp_vld, vt[i].exp_dat);
    idle(3);
    check("disabled_sel", 32'(digit_sel), 32'hF);
    check("disabled_seg", 32'(segments),  32'h7F);

    step(1'b1, 1'b0, 32'h400, 32'h0000_1A3F, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h404, 32'h0000_0001, 1'b0, 32'h0);
    idle(1);
    scan_check({4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h79, 7'h08, 7'h30, 7'h0E}, "scan");

    step(1'b1, 1'b0, 32'h404, 32'h0000_0201, 1'b0, 32'h0);
    idle(1);
    scan_check({4'b0111, 4'b1011, 4'b1111, 4'b1110}, {7'h79, 7'h08, 7'h30, 7'h0E}, "blank1");

    step(1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 32'h0);
    idle(2);
    for (int c = 0; c < 8; c++) begin
      check("off_sel", 32'(digit_sel), 32'hF);
      check("off_seg", 32'(segments),  32'h7F);
      @(negedge clk);
    end

    // Reset landing while a load response is on the bus.
    step(1'b1, 1'b0, 32'h404, 32'h1, 1'b0, 32'h0);
    idle(6);
    bus.rd_en    = 1'b1;
    bus.data_adr = 32'h400;
    @(posedge clk);
    #2;
    check("pre_rst_rd_valid", 32'(bus.rd_valid), 32'd1);
    rst          = 1'b0;
    bus.rd_en    = 1'b0;
    bus.data_adr = 32'h0;
    #1;
    check("arst_rd_valid",  32'(bus.rd_valid), 32'd0);
    check("arst_rd_data",   bus.rd_data,       32'h0);
    check("arst_segments",  32'(segments),     32'h7F);
    check("arst_digit_sel", 32'(digit_sel),    32'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 32'h408, 32'h0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h408, 32'h0, 1'b1, 32'h1);
    step(1'b0, 1'b1, 32'h400, 32'h0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h404, 32'h0, 1'b1, 32'h0);
    idle(4);

`ifdef SEG_BLINK_EN
    begin
      int dark;
      int i;
      step(1'b1, 1'b0, 32'h400, 32'h0000_1A3F, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h404, 32'h0000_0003, 1'b0, 32'h0);
      idle(2);
      wait_sel(4'b1111, 1'b0, 40, "blink_lit_start");
      dark = 0;
      for (i = 0; i < 1300 && dark < 24; i++) begin
        dark = (digit_sel == 4'b1111) ? dark + 1 : 0;
        @(negedge clk);
      end
      n_cmp++;
      if (dark < 24) begin
        n_bad++;
        $display("FAIL blink_dark: got longest dark run %0d expected 24", dark);
      end
      wait_sel(4'b1111, 1'b0, 1100, "blink_relit");
      idle(2);
    end
`endif

    idle(3);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_seg_responder.md
Name: mmio_seg_responder

Overview:
- Memory-mapped responder on the CPU data bus (mem_write / data_adr / write_data).
- Captures CPU stores into display registers and drives a time-multiplexed 4-digit seven-segment display.
- Returns register contents on CPU loads with one cycle of latency.
- Sits beside the CPU core in the board-level top and replaces direct decode of raw address bits to the display.

Parameters:
- BASE_ADDR, 32'h0000_0400, base of the 16-byte register window; must be 16-byte aligned.
- NUM_DIGITS, 4, number of multiplexed digits; range 1..8.
- SCAN_DIV, 50000, clk cycles per digit slot; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mem_write  in  1  CPU store strobe, sampled on posedge clk.
- rd_en  in  1  CPU load strobe, sampled on posedge clk.
- data_adr  in  32  CPU byte address.
- write_data  in  32  CPU store data.
- rd_data  out  32  load response data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- segments  out  7  active-low segments {g,f,e,d,c,b,a} for the current digit.
- digit_sel  out  NUM_DIGITS  active-low one-hot digit enable.

Behaviour:
- Address hit:
  - Requires data_adr[31:4]==BASE_ADDR[31:4] and data_adr[1:0]==0.
  - Offset is data_adr[3:2].
  - Any other address is ignored: no write, no rd_valid.
- Register map:
  - Offset 0 DATA: bits[4*NUM_DIGITS-1:0] hold hex nibbles, digit 0 = bits[3:0]. Upper bits read as 0.
  - Offset 1 CTRL: bit0 enable, bit1 blink (meaningful only with the optional feature), bits[15:8] per-digit blank mask. Other bits read as 0.
  - Offset 2 STATUS: read-only. bits[2:0] current digit index, bit8 blink phase. Writes are ignored.
  - Offset 3: reserved. Writes are ignored; reads return 0 with rd_valid asserted.
- Write: a register updates on the posedge where mem_write and address hit are both high. The new value is visible on the display from the next cycle.
- Read: rd_en with an address hit produces rd_valid=1 and rd_data at the next posedge, i.e. 1-cycle latency. rd_valid is 0 in every other cycle. rd_data holds its last value when rd_valid=0.
- Simultaneous mem_write and rd_en to the same register: the read returns the pre-write value.
- Scan prescaler:
  - Counter runs 0..SCAN_DIV-1 continuously.
  - At terminal count, digit index advances by one and wraps NUM_DIGITS-1 -> 0.
- Display output:
  - digit_sel asserts the current index only when CTRL.enable=1 and that digit's blank bit is 0. Otherwise digit_sel is all ones.
  - segments is the registered decode of the current nibble, so it changes in the same cycle as digit_sel.
  - When the display is disabled, segments=7'h7F.
- Reset (rst=0, asynchronous):
  - DATA=0, CTRL=0, prescaler=0, index=0.
  - rd_valid=0, rd_data=0, segments=7'h7F, digit_sel all ones.
  - Reset mid-scan or mid-read aborts immediately; no pending rd_valid is produced after release.
  - First digit advance occurs SCAN_DIV cycles after reset release.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - A frame counter increments each time the index wraps to 0.
  - Blink phase toggles every 64 frames.
  - While CTRL.blink=1 and the phase is 1, digit_sel is forced all ones.
  - STATUS bit8 reports the phase.
- Undefined:
  - No frame counter is built.
  - CTRL.blink is stored and readable but has no effect.
  - STATUS bit8 reads 0.

Decomposition:
- Package seg_mmio_pkg holds:
  - offset constants OFF_DATA=2'd0, OFF_CTRL=2'd1, OFF_STATUS=2'd2;
  - CTRL bit-position localparams;
  - BLINK_FRAMES=64.
- Sub-module hex_to_seg7: combinational 4-bit nibble to active-low 7-segment decode, 0-F. It is instantiated once on the muxed nibble and its output is registered in the parent.

Test Plan:
- Reset, then read DATA at 0x400 and CTRL at 0x404 -> rd_valid pulses one cycle after each rd_en; rd_data=0; digit_sel=4'b1111; segments=7'h7F.
- SCAN_DIV=4: write DATA=32'h0000_1A3F, then CTRL=1 -> digit_sel cycles 1110, 1101, 1011, 0111 every 4 clks; segments are 0x0E (F), 0x30 (3), 0x08 (A), 0x79 (1).
- Write CTRL=32'h0000_0201 -> digit 1 slot shows digit_sel=1111; the other three digits are unaffected.
- Same-cycle mem_write and rd_en to 0x400 (old value 0x1234, new value 0xBEEF) -> rd_data=0x1234; a following read returns 0xBEEF.
- Write to 0x402 (unaligned) and to 0x500 (outside the window) -> DATA unchanged and no rd_valid; read of 0x40C -> rd_valid=1, rd_data=0.
- Assert rst low mid-scan, one cycle after an rd_en -> all outputs reach their reset values without waiting for clk; no rd_valid after release. With SEG_BLINK_EN and CTRL=3, digits go dark after 64 frames and return after 128.
